uart_ctrl: RTL and testbench
============================

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 Parameter CLK_HZ, 20000000, frequency of sysclk in Hz.
REQ-002 Parameter BAUD, 115200, line rate in bit/s; DIV = CLK_HZ/BAUD, integer floor, must be at least 4.
REQ-003 sysclk  in  1  system clock; every flop uses its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 uart_datain  in  8  TX byte from the bus register.
REQ-006 uart_ctrlin  in  8  control: bit0 RXIE, bit1 TXIE, bit7 SRST; other bits ignored.
REQ-007 uart_wrh_n  in  1  active-low data write strobe, asynchronous to sysclk.
REQ-008 uart_rdh_n  in  1  active-low data read strobe, asynchronous to sysclk.
REQ-009 uart_dataout  out  8  RX byte at the head of the receive buffer.
REQ-010 uart_ctrlout  out  8  status: bit0 RXAV, bit1 TXE, bit2 TXBUSY, bit3 OVR, bit4 FE, bit5 RXFULL, bits 7:6 = 0.
REQ-011 rxd  in  1  serial input, asynchronous.
REQ-012 txd  out  1  serial output, idle high.
REQ-013 uart_int_n  out  1  active-low interrupt request, registered.

Function
REQ-014 uart_wrh_n, uart_rdh_n and rxd SHALL each pass through a 2-flop synchroniser before any use.
REQ-015 Write event: synchronised falling edge of uart_wrh_n; if TXE=1, load uart_datain into the holding register and clear TXE; if TXE=0, discard the byte and leave all state unchanged.
REQ-016 Read event: synchronised rising edge of uart_rdh_n; pop one RX entry if RXAV=1, then clear OVR and FE; with RXAV=0, take no action.
REQ-017 TX FSM states: IDLE, START, DATA, STOP. In IDLE with TXE=0, move the holding register to the shift register, set TXE=1, set TXBUSY=1, and enter START on the next cycle.
REQ-018 Each TX bit SHALL last exactly DIV sysclk cycles. Frame format is 8N1, LSB first: start bit 0, 8 data bits, stop bit 1.
REQ-019 TXBUSY clears on the last cycle of STOP; a pending holding byte then starts a new frame with no idle gap.
REQ-020 RX FSM states: IDLE, START, DATA, STOP.
- Leave IDLE on a synchronised falling edge of rxd.
- Sample rxd at DIV/2 into START; if rxd is high there, return to IDLE (glitch, no flag).
- Sample each data bit, then the stop bit, at DIV-cycle intervals from that point.
REQ-021 Stop bit sampled 0: discard the byte, set FE, return to IDLE.
REQ-022 Valid byte with the buffer full: drop the byte and set OVR.
REQ-023 Push and pop in the same cycle on a full buffer: perform both; OVR stays unchanged.
REQ-024 RXAV = buffer not empty. RXFULL = buffer full. uart_dataout = head entry, or 0 when empty.
REQ-025 uart_int_n = NOT((RXIE AND RXAV) OR (TXIE AND TXE)), registered with one cycle of latency.
REQ-026 SRST=1 SHALL hold both FSMs, the RX buffer and all flags at reset values for as long as it stays set; uart_ctrlin itself is unaffected.

Reset
REQ-027 On rst_n low, outputs SHALL take: txd=1, uart_dataout=8'h00, uart_ctrlout=8'h02, uart_int_n=1.
REQ-028 On rst_n low, internal state SHALL take: both FSMs IDLE, RX buffer empty, synchronisers preset to 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately and return txd to 1 with no partial stop bit.

Configuration
REQ-030 Macro UART_RX_FIFO_EN defined: the RX buffer is an 8-entry FIFO with 3-bit pointers that wrap modulo 8 and a separate 4-bit count.
REQ-031 UART_RX_FIFO_EN undefined: the RX buffer is a single holding register, and RXFULL = RXAV.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state encodings, the uart_ctrlin/uart_ctrlout bit-position constants and the 8N1 bit count.
REQ-033 The FIFO SHALL be sub-module uart_fifo (sync, parameterised depth and width); it is instantiated only when UART_RX_FIFO_EN is defined.

Verification (CLK_HZ=1600000, BAUD=100000, so DIV=16)
REQ-034 Write 8'hA5 -> txd low for 16 cycles, then bits 1,0,1,0,0,1,0,1, then high for 16 cycles; TXBUSY high throughout the frame.
REQ-035 Two writes issued back-to-back, the second while TXBUSY=1 -> the second frame starts on the cycle after the first stop bit ends; a third write issued while TXE=0 is discarded.
REQ-036 Drive 8'h3C on rxd -> RXAV=1 and uart_dataout=8'h3C; one read returns RXAV to 0; with RXIE=1, uart_int_n falls one cycle after RXAV rises.
REQ-037 FIFO build: send 9 bytes with no read -> RXFULL=1, OVR=1, the first 8 bytes are read back in order, and OVR clears on the first read.
REQ-038 Frame with stop bit 0 -> FE=1 and RXAV unchanged; a 0 pulse of 4 cycles on rxd -> no byte and no flag.
REQ-039 Assert rst_n mid-TX at data bit 3 -> txd=1 and uart_ctrlout=8'h02 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART controller: FSM encodings,
// control/status register bit positions and the 8N1 frame size.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // uart_ctrlin bit positions
    localparam int CTRL_RXIE = 0;
    localparam int CTRL_TXIE = 1;
    localparam int CTRL_SRST = 7;

    // uart_ctrlout bit positions
    localparam int STAT_RXAV   = 0;
    localparam int STAT_TXE    = 1;
    localparam int STAT_TXBUSY = 2;
    localparam int STAT_OVR    = 3;
    localparam int STAT_FE     = 4;
    localparam int STAT_RXFULL = 5;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO for the UART receive path; head entry is visible on rdata
// without a read. Only instantiated when UART_RX_FIFO_EN is defined.
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// UART controller, 8N1, with bus-side holding register for TX and a receive buffer.
// Define UART_RX_FIFO_EN for an 8-entry RX FIFO; otherwise RX holds a single byte.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 20000000,
    parameter int BAUD   = 115200
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [7:0] uart_datain,
    input  logic [7:0] uart_ctrlin,
    input  logic       uart_wrh_n,
    input  logic       uart_rdh_n,
    output logic [7:0] uart_dataout,
    output logic [7:0] uart_ctrlout,
    input  logic       rxd,
    output logic       txd,
    output logic       uart_int_n
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    // Control bits
    logic rxie;
    logic txie;
    logic srst;
    logic unused_ctrl;

    assign rxie        = uart_ctrlin[CTRL_RXIE];
    assign txie        = uart_ctrlin[CTRL_TXIE];
    assign srst        = uart_ctrlin[CTRL_SRST];
    assign unused_ctrl = ^uart_ctrlin[6:2];

    // Synchronisers plus one extra flop each for edge detection
    logic [1:0] wr_sync;
    logic [1:0] rd_sync;
    logic [1:0] rx_sync;
    logic       wr_prev;
    logic       rd_prev;
    logic       rx_prev;
    logic       wr_event;
    logic       rd_event;
    logic       rx_fall;
    logic       rx_bit;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync <= 2'b11;
            rd_sync <= 2'b11;
            rx_sync <= 2'b11;
            wr_prev <= 1'b1;
            rd_prev <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            wr_sync <= {wr_sync[0], uart_wrh_n};
            rd_sync <= {rd_sync[0], uart_rdh_n};
            rx_sync <= {rx_sync[0], rxd};
            wr_prev <= wr_sync[1];
            rd_prev <= rd_sync[1];
            rx_prev <= rx_sync[1];
        end
    end

    assign wr_event = wr_prev & ~wr_sync[1];
    assign rd_event = ~rd_prev & rd_sync[1];
    assign rx_fall  = rx_prev & ~rx_sync[1];
    assign rx_bit   = rx_sync[1];

    // ---------------------------------------------------------------- TX
    tx_state_t     tx_state;
    tx_state_t     tx_next;
    logic [7:0]    hold_q;
    logic [7:0]    tx_shift;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bits;
    logic          txe_q;
    logic          busy_q;
    logic          tx_bit_end;
    logic          tx_load;

    assign tx_bit_end = (tx_cnt == CW'(DIV - 1));

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!txe_q) begin
                    tx_load = 1'b1;
                    tx_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) tx_next = TX_DATA;
            end
            TX_DATA: begin
                if (tx_bit_end && tx_bits == 3'(DATA_BITS - 1)) tx_next = TX_STOP;
            end
            TX_STOP: begin
                // A byte waiting in the holding register chains straight into the next start bit.
                if (tx_bit_end) begin
                    if (!txe_q) begin
                        tx_load = 1'b1;
                        tx_next = TX_START;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
        if (srst) begin
            tx_next = TX_IDLE;
            tx_load = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= 8'h00;
            tx_shift <= 8'h00;
            tx_cnt   <= '0;
            tx_bits  <= 3'd0;
            txe_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else if (srst) begin
            tx_cnt   <= '0;
            tx_bits  <= 3'd0;
            txe_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_shift <= hold_q;
                tx_bits  <= 3'd0;
                txe_q    <= 1'b1;
                busy_q   <= 1'b1;
            end else if (wr_event && txe_q) begin
                hold_q <= uart_datain;
                txe_q  <= 1'b0;
            end
            if (tx_state == TX_STOP && tx_next == TX_IDLE) begin
                busy_q <= 1'b0;
            end
            if (tx_state == TX_DATA && tx_bit_end) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bits  <= tx_bits + 1'b1;
            end
            if (tx_state == TX_IDLE || tx_bit_end) begin
                tx_cnt <= '0;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    assign txd = (tx_state == TX_START) ? 1'b0 :
                 (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

    // ---------------------------------------------------------------- RX
    rx_state_t     rx_state;
    rx_state_t     rx_next;
    logic [7:0]    rx_shift;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bits;
    logic          rx_bit_end;
    logic          rx_push;
    logic          fe_set;

    assign rx_bit_end = (rx_cnt == CW'(DIV - 1));

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        fe_set  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) rx_next = RX_START;
            end
            RX_START: begin
                // Mid start bit: a line back high means a glitch, not a frame.
                if (rx_cnt == CW'(HALF - 1)) rx_next = rx_bit ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_bit_end && rx_bits == 3'(DATA_BITS - 1)) rx_next = RX_STOP;
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_next = RX_IDLE;
                    if (rx_bit) rx_push = 1'b1;
                    else        fe_set  = 1'b1;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
        if (srst) begin
            rx_next = RX_IDLE;
            rx_push = 1'b0;
            fe_set  = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift <= 8'h00;
            rx_cnt   <= '0;
            rx_bits  <= 3'd0;
        end else if (srst) begin
            rx_cnt   <= '0;
            rx_bits  <= 3'd0;
        end else begin
            if (rx_state == RX_IDLE) begin
                rx_bits <= 3'd0;
            end
            if (rx_state == RX_DATA && rx_bit_end) begin
                rx_shift <= {rx_bit, rx_shift[7:1]};
                rx_bits  <= rx_bits + 1'b1;
            end
            if (rx_state == RX_IDLE || rx_state != rx_next || rx_bit_end) begin
                rx_cnt <= '0;
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- RX buffer
    logic       rxav;
    logic       rxfull;
    logic [7:0] rx_head;
    logic       rx_pop;
    logic       push_ok;
    logic       ovr_set;
    logic       ovr_q;
    logic       fe_q;

    assign rx_pop  = rd_event && rxav && !srst;
    assign push_ok = rx_push && (!rxfull || rx_pop);
    assign ovr_set = rx_push && rxfull && !rx_pop;

`ifdef UART_RX_FIFO_EN
    logic fifo_empty;

    uart_fifo #(
        .DEPTH(8),
        .WIDTH(8)
    ) u_rx_fifo (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .clr   (srst),
        .push  (push_ok),
        .pop   (rx_pop),
        .wdata (rx_shift),
        .rdata (rx_head),
        .empty (fifo_empty),
        .full  (rxfull)
    );

    assign rxav = !fifo_empty;
`else
    logic [7:0] rx_hold;
    logic       rx_valid;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hold  <= 8'h00;
            rx_valid <= 1'b0;
        end else if (srst) begin
            rx_valid <= 1'b0;
        end else if (push_ok) begin
            rx_hold  <= rx_shift;
            rx_valid <= 1'b1;
        end else if (rx_pop) begin
            rx_valid <= 1'b0;
        end
    end

    assign rx_head = rx_hold;
    assign rxav    = rx_valid;
    assign rxfull  = rx_valid;
`endif

    // Simultaneous push and pop on a full buffer leaves OVR as it was.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
            fe_q  <= 1'b0;
        end else if (srst) begin
            ovr_q <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (rx_pop && !(rx_push && rxfull)) begin
                ovr_q <= 1'b0;
            end
            if (fe_set) begin
                fe_q <= 1'b1;
            end else if (rx_pop) begin
                fe_q <= 1'b0;
            end
        end
    end

    assign uart_dataout = rxav ? rx_head : 8'h00;

    always_comb begin
        uart_ctrlout              = 8'h00;
        uart_ctrlout[STAT_RXAV]   = rxav;
        uart_ctrlout[STAT_TXE]    = txe_q;
        uart_ctrlout[STAT_TXBUSY] = busy_q;
        uart_ctrlout[STAT_OVR]    = ovr_q;
        uart_ctrlout[STAT_FE]     = fe_q;
        uart_ctrlout[STAT_RXFULL] = rxfull;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            uart_int_n <= 1'b1;
        end else begin
            uart_int_n <= ~((rxie & rxav) | (txie & txe_q));
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl at DIV=16: TX frame shape, chaining and
// discard, RX receive/read, interrupt latency, overflow, framing error, glitch, resets.
module tb_uart_ctrl;

    localparam int DIV = 16;
`ifdef UART_RX_FIFO_EN
    localparam int RX_DEPTH = 8;
`else
    localparam int RX_DEPTH = 1;
`endif

    logic       sysclk;
    logic       rst_n;
    logic [7:0] uart_datain;
    logic [7:0] uart_ctrlin;
    logic       uart_wrh_n;
    logic       uart_rdh_n;
    logic [7:0] uart_dataout;
    logic [7:0] uart_ctrlout;
    logic       rxd;
    logic       txd;
    logic       uart_int_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int         gap_q[$];
    int         rx_model_cnt = 0;

    logic       tx_mon_en    = 1'b0;
    logic       tx_in_frame  = 1'b0;
    int         idle_run     = 0;
    logic       int_watch_en = 1'b0;
    logic       rxav_prev    = 1'b0;

    uart_ctrl #(
        .CLK_HZ(1600000),
        .BAUD  (100000)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .uart_datain (uart_datain),
        .uart_ctrlin (uart_ctrlin),
        .uart_wrh_n  (uart_wrh_n),
        .uart_rdh_n  (uart_rdh_n),
        .uart_dataout(uart_dataout),
        .uart_ctrlout(uart_ctrlout),
        .rxd         (rxd),
        .txd         (txd),
        .uart_int_n  (uart_int_n)
    );

    // Clock and watchdog
    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic write_byte(input logic [7:0] b);
        @(negedge sysclk);
        uart_datain = b;
        uart_wrh_n  = 1'b0;
        repeat (4) @(negedge sysclk);
        uart_wrh_n  = 1'b1;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        if (stop_bit && rx_model_cnt < RX_DEPTH) begin
            rx_q.push_back(b);
            rx_model_cnt++;
        end
        rxd = 1'b0;
        repeat (DIV) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge sysclk);
        end
        rxd = stop_bit;
        repeat (DIV) @(negedge sysclk);
        rxd = 1'b1;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic read_rx();
        logic [7:0] e;
        check("read_rxav", 32'(uart_ctrlout[0]), 32'd1);
        e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        if (rx_model_cnt > 0) rx_model_cnt--;
        check("rx_data", 32'(uart_dataout), 32'(e));
        uart_rdh_n = 1'b0;
        repeat (3) @(negedge sysclk);
        uart_rdh_n = 1'b1;
        repeat (5) @(negedge sysclk);
    endtask

    task automatic wait_tx_drain(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx_q.size() == 0 && !tx_in_frame) begin
                done = 1'b1;
                break;
            end
            @(negedge sysclk);
        end
        check("tx_drain", 32'(done), 32'd1);
    endtask

    // TX scoreboard: decode each frame cycle by cycle and compare with the expected queue
    logic [7:0] mon_exp;
    logic [7:0] mon_data;
    logic       mon_lvl;
    int         mon_shape;
    int         mon_busy;

    always begin : tx_monitor
        @(negedge sysclk);
        if (tx_mon_en && txd == 1'b0) begin
            tx_in_frame = 1'b1;
            gap_q.push_back(idle_run);
            check("tx_frame_expected", 32'(tx_q.size() != 0), 32'd1);
            mon_exp   = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
            mon_shape = 0;
            mon_busy  = 0;
            mon_data  = 8'h00;
            for (int c = 0; c < 10 * DIV; c++) begin
                if (c != 0) @(negedge sysclk);
                if (c < DIV)             mon_lvl = 1'b0;
                else if (c >= 9 * DIV)   mon_lvl = 1'b1;
                else                     mon_lvl = mon_exp[(c - DIV) / DIV];
                if (txd !== mon_lvl) mon_shape++;
                if (uart_ctrlout[2] === 1'b1) mon_busy++;
                if (c >= DIV && c < 9 * DIV && (c % DIV) == DIV / 2) mon_data[(c - DIV) / DIV] = txd;
            end
            check("tx_data", 32'(mon_data), 32'(mon_exp));
            check("tx_shape", 32'(mon_shape), 32'd0);
            check("tx_busy_cycles", 32'(mon_busy), 32'(10 * DIV));
            idle_run    = 0;
            tx_in_frame = 1'b0;
        end else if (idle_run < 100000) begin
            idle_run++;
        end
    end

    // Interrupt must follow RXAV rising by exactly one cycle
    always begin : int_watch
        @(negedge sysclk);
        if (int_watch_en && !rxav_prev && uart_ctrlout[0]) begin
            check("int_before_rxav", 32'(uart_int_n), 32'd1);
            @(negedge sysclk);
            check("int_after_rxav", 32'(uart_int_n), 32'd0);
        end
        rxav_prev = uart_ctrlout[0];
    end

    initial begin : main
        int zeros;
        logic started;
        rst_n       = 1'b0;
        uart_datain = 8'h00;
        uart_ctrlin = 8'h00;
        uart_wrh_n  = 1'b1;
        uart_rdh_n  = 1'b1;
        rxd         = 1'b1;
        repeat (3) @(negedge sysclk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_dataout", 32'(uart_dataout), 32'h00);
        check("rst_ctrlout", 32'(uart_ctrlout), 32'h02);
        check("rst_int_n", 32'(uart_int_n), 32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge sysclk);
        tx_mon_en = 1'b1;

        // Single TX frame
        tx_q.push_back(8'hA5);
        write_byte(8'hA5);
        wait_tx_drain(400);

        // Back-to-back frames and a discarded third write
        gap_q.delete();
        tx_q.push_back(8'h11);
        write_byte(8'h11);
        check("busy_before_2nd", 32'(uart_ctrlout[2]), 32'd1);
        tx_q.push_back(8'h22);
        write_byte(8'h22);
        check("txe_after_2nd", 32'(uart_ctrlout[1]), 32'd0);
        write_byte(8'h33);
        check("txe_after_discard", 32'(uart_ctrlout[1]), 32'd0);
        wait_tx_drain(800);
        repeat (20) @(negedge sysclk);
        check("tx_frame_count", 32'(gap_q.size()), 32'd2);
        check("tx_chain_gap", 32'((gap_q.size() > 1) ? gap_q[1] : -1), 32'd0);

        // RX byte with RXIE interrupt
        uart_ctrlin  = 8'h01;
        int_watch_en = 1'b1;
        send_rx(8'h3C, 1'b1);
        check("rx_rxav", 32'(uart_ctrlout[0]), 32'd1);
        read_rx();
        check("rx_rxav_after_read", 32'(uart_ctrlout[0]), 32'd0);
        int_watch_en = 1'b0;
        uart_ctrlin  = 8'h00;

        // A few random bytes, each read back
        for (int i = 0; i < 3; i++) begin
            send_rx(8'($urandom_range(0, 255)), 1'b1);
            read_rx();
        end

        // Short low glitch: no byte, no flag
        @(negedge sysclk);
        rxd = 1'b0;
        repeat (4) @(negedge sysclk);
        rxd = 1'b1;
        repeat (60) @(negedge sysclk);
        check("glitch_status", 32'(uart_ctrlout), 32'h02);

        // Framing error
        send_rx(8'h55, 1'b0);
        check("fe_set", 32'(uart_ctrlout[4]), 32'd1);
        check("fe_rxav", 32'(uart_ctrlout[0]), 32'd0);
        send_rx(8'h81, 1'b1);
        read_rx();
        check("fe_clear", 32'(uart_ctrlout[4]), 32'd0);

        // Overflow: one more byte than the buffer holds
        for (int i = 0; i <= RX_DEPTH; i++) begin
            send_rx(8'($urandom_range(0, 255)), 1'b1);
        end
        check("ovf_rxfull", 32'(uart_ctrlout[5]), 32'd1);
        check("ovf_ovr", 32'(uart_ctrlout[3]), 32'd1);
        for (int i = 0; i < RX_DEPTH; i++) begin
            read_rx();
            if (i == 0) check("ovr_clear", 32'(uart_ctrlout[3]), 32'd0);
        end
        check("ovf_drained", 32'(uart_ctrlout[5:0]), 32'h02);

        // TXIE interrupt
        uart_ctrlin = 8'h02;
        repeat (3) @(negedge sysclk);
        check("txie_int", 32'(uart_int_n), 32'd0);
        uart_ctrlin = 8'h00;
        repeat (3) @(negedge sysclk);
        check("txie_int_off", 32'(uart_int_n), 32'd1);

        // Soft reset clears RX buffer and flags
        send_rx(8'hC3, 1'b1);
        uart_ctrlin = 8'h80;
        repeat (2) @(negedge sysclk);
        check("srst_ctrlout", 32'(uart_ctrlout), 32'h02);
        check("srst_dataout", 32'(uart_dataout), 32'h00);
        uart_ctrlin = 8'h00;
        rx_q.delete();
        rx_model_cnt = 0;
        repeat (2) @(negedge sysclk);
        check("srst_release", 32'(uart_ctrlout[0]), 32'd0);

        // Hard reset mid-frame at data bit 3
        tx_mon_en   = 1'b0;
        started     = 1'b0;
        uart_datain = 8'h00;
        uart_wrh_n  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sysclk);
            if (txd == 1'b0) begin
                started = 1'b1;
                break;
            end
        end
        uart_wrh_n = 1'b1;
        check("rst_tx_started", 32'(started), 32'd1);
        repeat (4 * DIV + 6) @(negedge sysclk);
        check("pre_rst_txd", 32'(txd), 32'd0);
        check("pre_rst_busy", 32'(uart_ctrlout[2]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_txd", 32'(txd), 32'd1);
        check("mid_rst_ctrlout", 32'(uart_ctrlout), 32'h02);
        @(negedge sysclk);
        rst_n = 1'b1;
        zeros = 0;
        for (int i = 0; i < 12 * DIV; i++) begin
            @(negedge sysclk);
            if (txd !== 1'b1) zeros++;
        end
        check("post_rst_idle", 32'(zeros), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
